// File: rtl/mem_sequencer.sv
// mem_sequencer: turns one 1/2/4/8-byte big-endian load/store request into a
// sequence of byte transactions on an 8-bit memory port.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req, we, size, signext         request strobe, store/load, 2^size bytes, sign-extend loads
//   addr, wdata                    first (most significant) byte address, store data (low bytes)
//   busy, done, err, rdata         status, completion pulse, illegal-size pulse, load result
//   mem_data_out, mem_data_in      byte from / to memory
//   mem_raddr, mem_waddr           read / write byte address
//   mem_write, mem_ready           write strobe, memory ready (0 stalls the current byte)
module mem_sequencer #(
  parameter int unsigned addr_width   = 9,
  parameter int unsigned data_width   = 32,
  parameter int unsigned read_latency = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  signext,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [data_width-1:0] rdata,
  input  logic [7:0]            mem_data_out,
  output logic [7:0]            mem_data_in,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  input  logic                  mem_ready
);

  localparam int unsigned max_bytes = data_width / 8;
  localparam int unsigned lat_w     = (read_latency > 1) ? $clog2(read_latency) : 1;
  localparam logic [lat_w-1:0] lat_init = lat_w'(read_latency - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                state, state_nx;
  logic [1:0]            size_r, size_nx;
  logic                  signext_r, signext_nx;
  logic [addr_width-1:0] addr_r, addr_nx;
  logic [data_width-1:0] wdata_r, wdata_nx;
  logic [3:0]            idx, idx_nx;
  logic [lat_w-1:0]      lat, lat_nx;
  logic [data_width-1:0] asm_r, asm_nx;
  logic                  busy_nx, done_nx, err_nx, mem_write_nx;
  logic [data_width-1:0] rdata_nx;
  logic [addr_width-1:0] mem_raddr_nx, mem_waddr_nx;
  logic [7:0]            mem_data_in_nx;

  logic [3:0]            nb_r, idx_inc;
  logic                  last;
  logic [data_width-1:0] ones, fill_mask, sign_sh;

  // Byte k of d, counting from the least significant byte.
  function automatic logic [7:0] byte_of(input logic [data_width-1:0] d, input logic [3:0] k);
    logic [data_width-1:0] s;
    s = d >> {k, 3'b000};
    return s[7:0];
  endfunction

  always_comb begin
    state_nx       = state;
    size_nx        = size_r;
    signext_nx     = signext_r;
    addr_nx        = addr_r;
    wdata_nx       = wdata_r;
    idx_nx         = idx;
    lat_nx         = lat;
    asm_nx         = asm_r;
    busy_nx        = busy;
    done_nx        = 1'b0;
    err_nx         = 1'b0;
    rdata_nx       = rdata;
    mem_raddr_nx   = mem_raddr;
    mem_waddr_nx   = mem_waddr;
    mem_data_in_nx = mem_data_in;
    mem_write_nx   = mem_write;
    sign_sh        = '0;

    nb_r      = 4'd1 << size_r;
    idx_inc   = idx + 4'd1;
    last      = (idx_inc == nb_r);
    ones      = '1;
    // Bits above the access width; all-zero for a full-width access.
    fill_mask = ones << {nb_r, 3'b000};

    case (state)
      IDLE: begin
        if (req) begin
          size_nx    = size;
          signext_nx = signext;
          addr_nx    = addr;
          wdata_nx   = wdata;
          idx_nx     = '0;
          if ((32'd1 << size) > max_bytes) begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
            busy_nx = 1'b0;
          end else if (we) begin
            state_nx       = WRITE;
            busy_nx        = 1'b1;
            mem_waddr_nx   = addr;
            mem_data_in_nx = byte_of(wdata, (4'd1 << size) - 4'd1);
            mem_write_nx   = 1'b1;
          end else begin
            state_nx     = READ;
            busy_nx      = 1'b1;
            mem_raddr_nx = addr;
            lat_nx       = lat_init;
            asm_nx       = '0;
          end
        end
      end

      READ: begin
        if (mem_ready) begin
          if (lat == '0) begin
            asm_nx = (asm_r << 8) | data_width'(mem_data_out);
            if (last) begin
              sign_sh  = asm_nx >> (7'({nb_r, 3'b000}) - 7'd1);
              rdata_nx = (signext_r && sign_sh[0]) ? (asm_nx | fill_mask) : asm_nx;
              done_nx  = 1'b1;
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end else begin
              idx_nx       = idx_inc;
              mem_raddr_nx = addr_r + addr_width'(idx_inc);
              lat_nx       = lat_init;
            end
          end else begin
            lat_nx = lat - lat_w'(1);
          end
        end
      end

      WRITE: begin
        // mem_write is always high here, so mem_ready alone marks acceptance.
        if (mem_ready) begin
          if (last) begin
            mem_write_nx = 1'b0;
            done_nx      = 1'b1;
            busy_nx      = 1'b0;
            state_nx     = IDLE;
          end else begin
            idx_nx         = idx_inc;
            mem_waddr_nx   = addr_r + addr_width'(idx_inc);
            mem_data_in_nx = byte_of(wdata_r, nb_r - idx_inc - 4'd1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      size_r      <= '0;
      signext_r   <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      idx         <= '0;
      lat         <= '0;
      asm_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      mem_raddr   <= '0;
      mem_waddr   <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
    end else begin
      state       <= state_nx;
      size_r      <= size_nx;
      signext_r   <= signext_nx;
      addr_r      <= addr_nx;
      wdata_r     <= wdata_nx;
      idx         <= idx_nx;
      lat         <= lat_nx;
      asm_r       <= asm_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      err         <= err_nx;
      rdata       <= rdata_nx;
      mem_raddr   <= mem_raddr_nx;
      mem_waddr   <= mem_waddr_nx;
      mem_data_in <= mem_data_in_nx;
      mem_write   <= mem_write_nx;
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: requests push expected completions and
// expected write bytes into queues; independent monitors compare them against
// the memory port and the done/err/rdata outputs.
module tb_mem_sequencer;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst, req, we, signext, mem_ready;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy, done, err, mem_write;
  logic [DW-1:0] rdata;
  logic [7:0]    mem_data_out, mem_data_in;
  logic [AW-1:0] mem_raddr, mem_waddr;

  mem_sequencer #(.addr_width(AW), .data_width(DW), .read_latency(RL)) dut (
    .clk(clk), .reset(rst), .req(req), .we(we), .size(size), .signext(signext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_write(mem_write), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory as seen by the DUT, and the reference image the model reads from.
  logic [7:0]    mem     [0:(1<<AW)-1];
  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] rpipe;

  // Read data appears read_latency (=2) edges after the address is registered.
  always @(posedge clk) begin
    rpipe <= mem_raddr;
    if (mem_write === 1'b1 && mem_ready) mem[mem_waddr] = mem_data_in;
  end
  assign mem_data_out = mem[rpipe];

  typedef struct {
    bit            err;
    bit            load;
    logic [DW-1:0] rd;
    int unsigned   acc_cyc;
    int unsigned   base;
    int unsigned   stall0;
    logic [AW-1:0] raddr0;
  } exp_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  exp_t          eq[$];
  wr_t           wq[$];
  int            checks = 0;
  int            errors = 0;
  int unsigned   cyc = 0;
  int unsigned   stall_total = 0;
  int            last_acc = 0;
  int            win_s = 0;
  int            win_len = 0;
  bit            rand_ready = 0;
  logic [DW-1:0] model_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // mem_ready driver; counts every busy edge that sees mem_ready=0.
  always @(negedge clk) begin
    int e;
    bit r;
    e = int'(cyc) + 1 - last_acc;
    r = 1'b1;
    if (rand_ready && $urandom_range(3) == 0) r = 1'b0;
    if (win_len > 0 && e >= win_s && e < win_s + win_len) r = 1'b0;
    mem_ready = r;
    if (busy === 1'b1 && !r) stall_total++;
  end

  // An accepted byte becomes part of the reference memory image.
  always @(posedge clk) begin
    if (!rst && mem_write === 1'b1 && mem_ready && wq.size() > 0) begin
      ref_mem[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
  end

  // Monitor: write-port contents and completions.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_write === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected actual=%0h/%0h required=no write", mem_waddr, mem_data_in);
        end else begin
          check("write_byte", {mem_waddr, mem_data_in}, {wq[0].a, wq[0].d});
        end
      end
      if (done === 1'b1) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 required=0");
        end else begin
          e = eq.pop_front();
          check("err", 64'(err), 64'(e.err));
          check("rdata", 64'(rdata), 64'(e.rd));
          check("done_latency", 64'(cyc - e.acc_cyc), 64'(e.base + stall_total - e.stall0));
          if (e.err) check("raddr_hold", 64'(mem_raddr), 64'(e.raddr0));
        end
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=%b required=0", busy);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_t        e;
    wr_t         wr;
    int unsigned n;
    longint      v;
    wait_idle();
    n        = 1 << sz;
    e.err    = 0;
    e.load   = !w;
    e.acc_cyc = cyc + 1;
    e.stall0 = stall_total;
    e.raddr0 = mem_raddr;
    if (n > DW / 8) begin
      e.err  = 1;
      e.base = 0;
      e.rd   = model_rdata;
    end else if (w) begin
      e.base = n;
      e.rd   = model_rdata;
      for (int i = 0; i < int'(n); i++) begin
        wr.a = AW'(int'(a) + i);
        wr.d = 8'(wd >> (8 * (int'(n) - 1 - i)));
        wq.push_back(wr);
      end
    end else begin
      v = 0;
      for (int i = 0; i < int'(n); i++) v = v * 256 + longint'(ref_mem[AW'(int'(a) + i)]);
      if (sx && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      model_rdata = DW'(v);
      e.rd   = model_rdata;
      e.base = n * RL;
    end
    eq.push_back(e);
    last_acc = int'(cyc) + 1;
    req      = 1'b1;
    we       = w;
    size     = sz;
    signext  = sx;
    addr     = a;
    wdata    = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = '0; signext = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      b = 8'($urandom);
      poke(AW'(i), b);
    end
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({busy, done, err, rdata, mem_raddr, mem_waddr, mem_data_in, mem_write}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word load 12 34 56 78.
    poke(9'h010, 8'h12); poke(9'h011, 8'h34); poke(9'h012, 8'h56); poke(9'h013, 8'h78);
    issue(0, 2'd2, 0, 9'h010, '0);
    // Byte 0x80 signed and unsigned.
    poke(9'h020, 8'h80);
    issue(0, 2'd0, 1, 9'h020, '0);
    issue(0, 2'd0, 0, 9'h020, '0);
    // Halfword wrapping past the top of the address space.
    poke(9'h1FF, 8'hAB); poke(9'h000, 8'hCD);
    issue(0, 2'd1, 0, 9'h1FF, '0);
    // Word store, then the same store stalled for 3 cycles on its second byte.
    issue(1, 2'd2, 0, 9'h040, 32'hDEADBEEF);
    win_s = 2; win_len = 3;
    issue(1, 2'd2, 0, 9'h040, 32'hDEADBEEF);
    wait_idle();
    win_len = 0;
    issue(0, 2'd2, 1, 9'h040, '0);
    // Illegal size, immediately followed by a back-to-back request.
    issue(0, 2'd3, 0, 9'h055, '0);
    issue(0, 2'd1, 1, 9'h011, '0);

    // Reset in the middle of a word store: two bytes land, the rest never do.
    issue(1, 2'd2, 0, 9'h080, 32'hCAFEF00D);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_access",
             64'({busy, done, err, rdata, mem_raddr, mem_waddr, mem_data_in, mem_write}), 64'd0);
    eq.delete();
    wq.delete();
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 2'd0, 0, 9'h081, '0);
    issue(0, 2'd1, 0, 9'h082, '0);

    // Randomised traffic with random mem_ready stalls.
    rand_ready = 1;
    for (int k = 0; k < 150; k++) begin
      issue(bit'($urandom_range(1)), 2'($urandom_range(3)), bit'($urandom_range(1)),
            AW'($urandom), DW'($urandom));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end

    begin
      int guard = 0;
      while (eq.size() > 0 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (eq.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d pending required=0", eq.size());
      end
    end
    check("writes_drained", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Parametrised byte-serial load/store sequencer: turns a single request for a 1-, 2-, 4- or 8-byte big-endian access into a sequence of byte transactions on the SoC's 8-bit memory port. It is the next generation of the multi-cycle load/store logic inside the CPU, generalised in data width and read latency. Unlike that logic it honours `mem_ready` stalls, optionally sign-extends reads and flags illegal sizes. It sits between a CPU core's execute stage and the byte-wide RAM/peripheral bus.

## Interface

- `addr_width`, 9, memory address width in bits
- `data_width`, 32, maximum access width; legal values are 8, 16, 32, 64
- `read_latency`, 2, cycles from `mem_raddr` registered to `mem_data_out` sampled; legal values are ≥1

Ports:

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `req`  in  1  request strobe, sampled when `busy`=0
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  access is 2^size bytes
- `signext`  in  1  load result sign-extended when 1, zero-extended when 0
- `addr`  in  addr_width  first (most significant) byte address
- `wdata`  in  data_width  store data; the low 2^size bytes are used
- `busy`  out  1  access in progress
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse together with `done` on an illegal size
- `rdata`  out  data_width  load result, held until the next load completes
- `mem_data_out`  in  8  byte from memory
- `mem_data_in`  out  8  byte to memory
- `mem_raddr`  out  addr_width  read address
- `mem_waddr`  out  addr_width  write address
- `mem_write`  out  1  write strobe
- `mem_ready`  in  1  memory ready; when 0, the current byte transaction stalls

## Operation

- States: IDLE, READ, WRITE.
- **IDLE.** On `req`, latch `we`, `size`, `signext`, `addr`, `wdata`. Set `busy`=1 and byte index i=0.
  - If 2^size > data_width/8: pulse `done`+`err`, clear `busy`, stay in IDLE. No memory activity.
  - Otherwise go to READ or WRITE.
- **READ, per byte:**
  - Register `mem_raddr` = addr+i and load the latency counter with read_latency−1.
  - The counter decrements only on edges with `mem_ready`=1.
  - On the edge where counter=0 and `mem_ready`=1: shift `mem_data_out` into the assembly register (big-endian, first byte most significant), increment i, and register the next `mem_raddr` on the same edge.
  - On the last byte, write `rdata` with the assembled value, zero- or sign-extended from bit 8·2^size−1 per `signext`. Pulse `done`, clear `busy`, go to IDLE.
- **WRITE, per byte:**
  - Register `mem_waddr` = addr+i, `mem_data_in` = byte (2^size−1−i) of `wdata`, and `mem_write`=1.
  - The byte is accepted on an edge with `mem_write`=1 and `mem_ready`=1.
  - While `mem_ready`=0, `mem_write`, `mem_waddr` and `mem_data_in` are held stable.
  - On acceptance of the last byte: drop `mem_write`, pulse `done`, clear `busy`, go to IDLE.
- Address arithmetic wraps modulo 2^addr_width; wrapping is not an error.
- `req` while `busy`=1 is ignored.
- `busy` falls on the same edge `done` rises, so a `req` during the `done` cycle is accepted.
- `rdata` is unchanged by stores and by errored requests.

## Timing

- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-access:** reset asynchronously forces outputs to 0 and returns to IDLE. Bytes already written stay written; the access is not completed and `done` does not pulse.
- Accept edge is E0.
- **Load with no stalls:**
  - First `mem_raddr` is valid after E0.
  - Byte k is sampled at E0+(k+1)·read_latency.
  - `done`/`rdata` are valid in the cycle after E0+n·read_latency, where n = 2^size.
- **Store with no stalls:**
  - `mem_write` is high for n consecutive cycles starting after E0.
  - `done` is high in the cycle after E0+n.
- Each cycle of `mem_ready`=0 inside a byte transaction adds exactly one cycle.
- **Illegal size:** `done`/`err` are high in the cycle after E0.

## Test plan

- Word load, addr 0x010, memory bytes 12 34 56 78, read_latency 2, `mem_ready`=1 → `mem_raddr` steps 0x010..0x013; `rdata`=0x12345678 with `done` in the cycle after E0+8.
- Byte load at 0x020 holding 0x80 → `signext`=1 gives 0xFFFFFF80, `signext`=0 gives 0x00000080.
- Halfword load at 0x1FF with bytes AB (0x1FF), CD (0x000) → addresses wrap; `rdata`=0x0000ABCD, `err`=0.
- Word store 0xDEADBEEF at 0x040 → four consecutive `mem_write` cycles with (`mem_waddr`, `mem_data_in`) = (0x040,DE), (0x041,AD), (0x042,BE), (0x043,EF); `done` in the cycle after E0+4.
- Same store with `mem_ready`=0 for 3 cycles during the second byte → `mem_write`=1, 0x041/AD held stable; `done` 3 cycles later than in the unstalled store.
- `size`=3 with data_width 32 → `done` and `err` high for one cycle after E0; `mem_write` stays 0 and `mem_raddr` is unchanged. Then reset asserted mid-word-store → all outputs 0 immediately, and a following byte load completes normally.
